mc_ctrl_fsm: RTL and testbench

- Multi-cycle MIPS control unit that sequences the shared datapath: one memory port, one ALU, IR/MDR/A/B/ALUOut registers.
- Replaces single-cycle decode with a per-instruction state sequence.
- Supports R-type, lw, sw, beq, j and addi.
- Stalls on a memory ready handshake.
- Sits between the IR opcode field and all datapath mux selects and write enables.

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_ctrl_outdec.sv | 82 ++++++++
 rtl/mc_ctrl_fsm.sv | 123 ++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Optional overflow trap is enabled by defining MC_OVF_TRAP_EN.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_EXC      = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       epc_write;
        logic       cause_write;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State-to-control decoder; Mealy terms are mem_ready in FETCH and zero in pc_en.
// EXC decode exists only when MC_OVF_TRAP_EN is defined.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
`ifdef MC_OVF_TRAP_EN
            S_EXC: begin
                ctrl.epc_write   = 1'b1;
                ctrl.cause_write = 1'b1;
                ctrl.pc_write    = 1'b1;
                ctrl.pc_source   = PCSRC_EXC;
            end
`endif
            default: ctrl = '0;
        endcase
        ctrl.pc_en = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: state register, opcode latch, next state.
// Define MC_OVF_TRAP_EN to trap signed overflow of R-type/addi into EXC.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               overflow,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               pc_en,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               EPCWrite,
    output logic               CauseWrite
);

    state_t     state_q, state_d;
    logic [5:0] opc_q, opc_d;
    ctrl_t      ctrl;

`ifndef MC_OVF_TRAP_EN
    logic unused_ovf;
    assign unused_ovf = overflow;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                opc_d = opcode;
                unique case (1'b1)
                    (opcode == OP_R):    state_d = S_EXEC;
                    (opcode == OP_LW),
                    (opcode == OP_SW):   state_d = S_MEM_ADDR;
                    (opcode == OP_BEQ):  state_d = S_BRANCH;
                    (opcode == OP_J):    state_d = S_JUMP;
                    (opcode == OP_ADDI): state_d = S_ADDI_EX;
                    default:             state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                state_d = (opc_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
            end
`ifdef MC_OVF_TRAP_EN
            S_EXEC:    state_d = overflow ? S_EXC : S_R_WB;
            S_ADDI_EX: state_d = overflow ? S_EXC : S_ADDI_WB;
            S_EXC:     state_d = S_FETCH;
`else
            S_EXEC:    state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
`endif
            S_R_WB:    state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ADDI_WB: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    assign state_out   = STATE_W'(state_q);
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign pc_en       = ctrl.pc_en;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign EPCWrite    = ctrl.epc_write;
    assign CauseWrite  = ctrl.cause_write;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Cycle-vector bench for mc_ctrl_fsm with an independent control model.
// Overflow row expectation follows MC_OVF_TRAP_EN.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic       mem_ready = 1'b1;
    logic [3:0] state_out;
    logic       PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       EPCWrite, CauseWrite;

    typedef struct packed {
        logic       pcw, pcwc, pce, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       epc, cause;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z, ov, mr;
        logic [3:0] st;
    } vec_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       ctl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    ctl_t act;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .overflow(overflow), .mem_ready(mem_ready),
        .state_out(state_out), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .pc_en(pc_en), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite)
    );

    assign act = {PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite,
                  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                  ALUOp, PCSource, EPCWrite, CauseWrite};

    function automatic ctl_t model(logic [3:0] s, logic mr, logic z);
        ctl_t c = '0;
        case (s)
            4'd1:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
            4'd2:  c.srcb = 2'b11;
            4'd3:  begin c.srca = 1; c.srcb = 2'b10; end
            4'd4:  begin c.mrd = 1; c.iord = 1; end
            4'd5:  begin c.m2r = 1; c.rw = 1; end
            4'd6:  begin c.mwr = 1; c.iord = 1; end
            4'd7:  begin c.srca = 1; c.aluop = 2'b10; end
            4'd8:  begin c.rdst = 1; c.rw = 1; end
            4'd9:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            4'd10: begin c.pcw = 1; c.pcsrc = 2'b10; end
            4'd11: begin c.srca = 1; c.srcb = 2'b10; end
            4'd12: c.rw = 1;
`ifdef MC_OVF_TRAP_EN
            4'd13: begin c.epc = 1; c.cause = 1; c.pcw = 1; c.pcsrc = 2'b11; end
`endif
            default: c = '0;
        endcase
        c.pce = c.pcw | (c.pcwc & z);
        return c;
    endfunction

    task automatic chk(string name, logic [31:0] a, logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    task automatic add(logic r, logic [5:0] op, logic z, logic ov,
                       logic mr, logic [3:0] st);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.ov = ov; v.mr = mr; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic step(vec_t v, int idx);
        exp_t e, g;
        rst = v.rst; opcode = v.op; zero = v.z;
        overflow = v.ov; mem_ready = v.mr;
        e.st = v.st;
        e.ctl = model(v.st, v.mr, v.z);
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk($sformatf("state[%0d]", idx), 32'(state_out), 32'(g.st));
        chk($sformatf("ctrl[%0d]", idx), 32'(act), 32'(g.ctl));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) add(1, 6'h00, 0, 0, 1, 4'd0);
        add(0, 6'h00, 0, 0, 1, 4'd0);
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b100011, 0, 0, 1, 4'd2);
        add(0, 6'b101011, 0, 0, 1, 4'd3);
        add(0, 6'h00, 0, 0, 1, 4'd4);
        add(0, 6'h00, 0, 0, 1, 4'd5);
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b101011, 0, 0, 1, 4'd2);
        add(0, 6'b100011, 0, 0, 1, 4'd3);
        add(0, 6'h00, 0, 0, 0, 4'd6);
        add(0, 6'h00, 0, 0, 0, 4'd6);
        add(0, 6'h00, 0, 0, 0, 4'd6);
        add(0, 6'h00, 0, 0, 1, 4'd6);
        add(0, 6'h00, 0, 0, 0, 4'd1);
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b000100, 0, 0, 1, 4'd2);
        add(0, 6'h00, 1, 0, 1, 4'd9);
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b000100, 0, 0, 1, 4'd2);
        add(0, 6'h00, 0, 0, 1, 4'd9);
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b000010, 0, 0, 1, 4'd2);
        add(0, 6'h00, 0, 0, 1, 4'd10);
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b111111, 0, 0, 1, 4'd2);
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b000000, 0, 0, 1, 4'd2);
        add(0, 6'h00, 0, 1, 1, 4'd7);
`ifdef MC_OVF_TRAP_EN
        add(0, 6'h00, 0, 0, 1, 4'd13);
`else
        add(0, 6'h00, 0, 0, 1, 4'd8);
`endif
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b001000, 0, 0, 1, 4'd2);
        add(0, 6'h00, 0, 0, 1, 4'd11);
        add(0, 6'h00, 0, 0, 1, 4'd12);
        add(0, 6'h00, 0, 0, 1, 4'd1);
        add(0, 6'b100011, 0, 0, 1, 4'd2);
        add(0, 6'h00, 0, 0, 1, 4'd3);
        add(0, 6'h00, 0, 0, 0, 4'd4);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        mem_ready = 1'b0;
        #1;
        chk("rd_wait_state", 32'(state_out), 32'd4);
        chk("rd_wait_memread", 32'(MemRead), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state_out), 32'd0);
        chk("async_rst_memread", 32'(MemRead), 32'd0);
        chk("async_rst_iord", 32'(IorD), 32'd0);
        @(negedge clk);
        chk("rst_hold_state", 32'(state_out), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rel_state", 32'(state_out), 32'd0);
        chk("rst_rel_ctrl", 32'(act), 32'd0);
        @(negedge clk);
        #1;
        chk("resume_state", 32'(state_out), 32'd1);
        chk("resume_memread", 32'(MemRead), 32'd1);
        chk("resume_irwrite", 32'(IRWrite), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
